// File: rtl/nios_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nios_timer_pkg
// Description : Shared register offsets and bit indices for the multi-channel
//               Avalon-MM interval timer.
// Revision    : 1.0 - initial release
// ============================================================================
package nios_timer_pkg;

  // Per-channel register offsets (address[2:0])
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIODL  = 3'd2;
  localparam logic [2:0] REG_PERIODH  = 3'd3;
  localparam logic [2:0] REG_SNAPL    = 3'd4;
  localparam logic [2:0] REG_SNAPH    = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam logic [2:0] REG_RESERVED = 3'd7;

  // CONTROL bit indices: ITO/CONT are stored, START/STOP are write strobes
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // STATUS bit indices
  localparam int STS_TO  = 0;
  localparam int STS_RUN = 1;

endpackage : nios_timer_pkg
`default_nettype wire

// File: rtl/nios_timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : nios_timer_channel
// Description : One interval-timer channel: prescaler, down-counter, RUN/TO
//               flags, period, snapshot and control bits, plus its local
//               register read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module nios_timer_channel #(
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 16,
  parameter logic [31:0] RESET_PERIOD = 32'hC34F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  reg_sel,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq,
  output logic        timeout_tick
);
  import nios_timer_pkg::*;

  localparam int               HI_W    = CNT_W - 16;
  localparam logic [CNT_W-1:0] RST_VAL = RESET_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] period_new;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] snap;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic             run;
  logic             to;
  logic             ito;
  logic             cont;

  logic wr_status;
  logic wr_ctrl;
  logic wr_perl;
  logic wr_perh;
  logic wr_period;
  logic wr_snap;
  logic wr_pre;
  logic start;
  logic stop;
  logic tick;
  logic cnt_zero;
  logic timeout_evt;

  assign wr_status = wr_en && (reg_sel == REG_STATUS);
  assign wr_ctrl   = wr_en && (reg_sel == REG_CONTROL);
  assign wr_perl   = wr_en && (reg_sel == REG_PERIODL);
  assign wr_perh   = wr_en && (reg_sel == REG_PERIODH);
  assign wr_period = wr_perl || wr_perh;
  assign wr_snap   = wr_en && ((reg_sel == REG_SNAPL) || (reg_sel == REG_SNAPH));
  assign wr_pre    = wr_en && (reg_sel == REG_PRESCALE);

  assign start = wr_ctrl && wdata[CTL_START];
  assign stop  = wr_ctrl && wdata[CTL_STOP];

  // Prescaler tick, and a timeout when the counter is already at zero on a tick
  assign tick        = run && (pre_cnt == '0);
  assign cnt_zero    = (counter == '0);
  assign timeout_evt = tick && cnt_zero;

  assign irq = to && ito;

  // Merge a PERIODL/PERIODH write into the current period (upper PERIODH bits dropped)
  always_comb begin
    period_new = period;
    if (wr_perl) begin
      period_new[15:0] = wdata;
    end
    if (wr_perh) begin
      period_new[CNT_W-1:16] = wdata[HI_W-1:0];
    end
  end

  // Software-visible configuration: period, prescale, ITO/CONT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period   <= RST_VAL;
      prescale <= '0;
      ito      <= 1'b0;
      cont     <= 1'b0;
    end else begin
      if (wr_period) begin
        period <= period_new;
      end
      if (wr_pre) begin
        prescale <= wdata[PRE_W-1:0];
      end
      if (wr_ctrl) begin
        ito  <= wdata[CTL_ITO];
        cont <= wdata[CTL_CONT];
      end
    end
  end

  // Prescaler and down-counter; a period write force-reloads both
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter <= RST_VAL;
      pre_cnt <= '0;
    end else if (wr_period) begin
      counter <= period_new;
      pre_cnt <= prescale;
    end else if (run) begin
      pre_cnt <= (pre_cnt == '0) ? prescale : pre_cnt - 1'b1;
      if (tick) begin
        counter <= cnt_zero ? period : counter - 1'b1;
      end
    end
  end

  // RUN and TO flags: START beats STOP and one-shot stop; a timeout beats a TO clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run          <= 1'b0;
      to           <= 1'b0;
      timeout_tick <= 1'b0;
    end else begin
      timeout_tick <= timeout_evt;
      if (wr_period) begin
        run <= 1'b0;
      end else if (start) begin
        run <= 1'b1;
      end else if (stop) begin
        run <= 1'b0;
      end else if (timeout_evt && !cont) begin
        run <= 1'b0;
      end
      if (timeout_evt) begin
        to <= 1'b1;
      end else if (wr_status) begin
        to <= 1'b0;
      end
    end
  end

  // Snapshot latches the live counter on a write to either SNAP register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap <= '0;
    end else if (wr_snap) begin
      snap <= counter;
    end
  end

  // Local register read mux; unused high bits read as zero
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: begin
        rdata[STS_TO]  = to;
        rdata[STS_RUN] = run;
      end
      REG_CONTROL: begin
        rdata[CTL_ITO]  = ito;
        rdata[CTL_CONT] = cont;
      end
      REG_PERIODL:  rdata = period[15:0];
      REG_PERIODH:  rdata[HI_W-1:0] = period[CNT_W-1:16];
      REG_SNAPL:    rdata = snap[15:0];
      REG_SNAPH:    rdata[HI_W-1:0] = snap[CNT_W-1:16];
      REG_PRESCALE: rdata[PRE_W-1:0] = prescale;
      default:      rdata = '0;
    endcase
  end

endmodule : nios_timer_channel
`default_nettype wire

// File: rtl/nios_multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : nios_multi_timer
// Description : NUM_CH-channel Avalon-MM interval timer. Decodes {channel,reg},
//               registers the selected read data and ORs the channel IRQs.
// Revision    : 1.0 - initial release
// ============================================================================
module nios_multi_timer #(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 16,
  parameter logic [31:0] RESET_PERIOD = 32'hC34F
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [2+$clog2(NUM_CH):0]   address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [15:0]                 writedata,
  output logic [15:0]                 readdata,
  output logic                        irq,
  output logic [NUM_CH-1:0]           irq_vec,
  output logic [NUM_CH-1:0]           timeout_tick
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]         ch_sel;
  logic [2:0]              reg_sel;
  logic                    wr_strobe;
  logic [NUM_CH-1:0][15:0] ch_rdata;
  logic [15:0]             rd_mux;

  assign reg_sel   = address[2:0];
  assign wr_strobe = chipselect && !write_n;

  generate
    if (NUM_CH > 1) begin : g_ch_idx
      assign ch_sel = address[2+$clog2(NUM_CH):3];
    end else begin : g_ch_single
      assign ch_sel = '0;
    end
  endgenerate

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic wr_en;
      assign wr_en = wr_strobe && (ch_sel == CH_W'(i));

      nios_timer_channel #(
        .CNT_W        (CNT_W),
        .PRE_W        (PRE_W),
        .RESET_PERIOD (RESET_PERIOD)
      ) u_channel (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .reg_sel      (reg_sel),
        .wdata        (writedata),
        .rdata        (ch_rdata[i]),
        .irq          (irq_vec[i]),
        .timeout_tick (timeout_tick[i])
      );
    end
  endgenerate

  // Channel read mux; an unpopulated channel index reads zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        rd_mux = ch_rdata[i];
      end
    end
  end

  // Read data is registered every clock regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |irq_vec;

endmodule : nios_multi_timer
`default_nettype wire
